mult_div_ctrl: RTL and testbench
================================

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-003 Port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-004 Port `start`, input, 1 bit: operation request, sampled on the rising edge.
REQ-005 Port `op`, input, 1 bit: 0 = MULTU, 1 = DIVU; sampled with `start`.
REQ-006 Port `src_a`, input, 32 bits: multiplicand or dividend (unsigned).
REQ-007 Port `src_b`, input, 32 bits: multiplier or divisor (unsigned).
REQ-008 Port `busy`, output, 1 bit: high while an operation is iterating.
REQ-009 Port `done`, output, 1 bit: one-cycle pulse; `hi`/`lo` are valid in this cycle.
REQ-010 Port `hi`, output, 32 bits: product[63:32], or remainder.
REQ-011 Port `lo`, output, 32 bits: product[31:0], or quotient.
REQ-012 Port `div_zero`, output, 1 bit: the last DIVU had divisor 0.

Function
REQ-013 The controller SHALL implement states IDLE, RUN and DONE; the encoding is free.
REQ-014 IDLE/DONE with `start`=1: the block SHALL latch `op`, `src_a`, `src_b` and clear the iteration counter; next state RUN.
- Exception: DIVU with `src_b`=0 goes directly to DONE (REQ-020).
REQ-015 IDLE/DONE with `start`=0: next state IDLE.
REQ-016 RUN: one iteration per cycle; a 5-bit counter runs 0..31; RUN SHALL go to DONE after the cycle with counter=31.
- This gives exactly 32 RUN cycles.
REQ-017 Latency: `start` sampled at edge T, so RUN occupies cycles T+1..T+32. `done`=1 in cycle T+33 only.
REQ-018 MULTU SHALL use shift-add: a 64-bit accumulator; each cycle, if multiplier LSB=1, add the multiplicand to the upper half (33-bit sum incl. carry), then shift the whole accumulator right by 1.
REQ-019 DIVU SHALL use restoring division: each cycle shift {rem,quot} left by 1 and subtract the divisor from rem.
- If the 33-bit difference is non-negative: keep it and set quot bit0=1.
- Otherwise: restore rem and set quot bit0=0.
REQ-020 DIVU with `src_b`=0: no RUN state; `done` SHALL pulse at T+1 with `lo`=32'hFFFFFFFF, `hi`=`src_a` and `div_zero`=1.
REQ-021 `div_zero` SHALL be 0 after any MULTU or any DIVU with a non-zero divisor; it is updated together with `hi`/`lo`.
REQ-022 `hi`/`lo` SHALL update only on the edge entering DONE and hold that value until the next DONE or reset; intermediate values SHALL NOT appear on `hi`/`lo`.
REQ-023 `busy` SHALL be 1 exactly in RUN cycles; `done` SHALL be 1 exactly in DONE cycles.
REQ-024 `start` while in RUN SHALL be ignored: no restart and no queuing.
REQ-025 Changes to `src_a`, `src_b` or `op` after acceptance SHALL NOT affect the result.
REQ-026 `start` in the DONE cycle SHALL be accepted, allowing back-to-back operations with no IDLE gap.

Reset
REQ-027 `rst`=1 at an edge SHALL force state IDLE, counter 0, `busy`=0, `done`=0, `div_zero`=0, `hi`=0 and `lo`=0.
REQ-028 Reset SHALL have priority over `start`; reset during RUN SHALL abort the operation with no `done` pulse.
REQ-029 In the first cycle after `rst` deasserts, `start` SHALL be accepted normally.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> `busy` high for 32 cycles, then `done` at T+33 with `hi`=0xFFFFFFFE, `lo`=0x00000001, `div_zero`=0.
REQ-031 DIVU 100 / 7 -> `done` at T+33 with `lo`=14, `hi`=2; DIVU 0x80000000 / 1 -> `lo`=0x80000000, `hi`=0.
REQ-032 DIVU 5 / 0 -> `done` at T+1, `busy` never high, `lo`=0xFFFFFFFF, `hi`=5, `div_zero`=1; a following MULTU 3 x 4 -> `lo`=12, `hi`=0, `div_zero`=0.
REQ-033 MULTU 6 x 7 with `start` re-pulsed at RUN cycle 10 and `src_a` changed to 9 -> single `done` at T+33, `lo`=42.
REQ-034 `rst` asserted at RUN cycle 10 of MULTU 3 x 5 (prior result `lo`=12) -> next cycle IDLE, `busy`=0, `hi`=`lo`=0, no `done` pulse.
REQ-035 `start` held during the DONE cycle of MULTU 2 x 3 with DIVU 9 / 2 presented -> `lo`=6 in first `done`; second `done` exactly 33 cycles later with `lo`=4, `hi`=1.

Source files
------------

// File: rtl/mult_div_ctrl.sv
// Iterative 32x32 unsigned multiply (shift-add) and divide (restoring)
// controller. One iteration per clock, 32 iterations per operation.
// Results appear on hi/lo only when an operation completes, and hold there.
module mult_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  cnt;
  logic        op_q;
  logic [31:0] opnd_q;
  logic [63:0] acc;
  logic [63:0] acc_next;
  logic [32:0] sum;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic        zero_div;

  // A divide with a zero divisor skips iteration and completes immediately
  always_comb begin
    zero_div = op && (src_b == 32'd0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs; start is only honoured outside RUN
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_next = zero_div ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 5'd31) begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One iteration step. For multiply acc is {partial product, multiplier}
  // and the 33-bit sum keeps the carry that shifts into bit 63. For divide
  // acc is {remainder, quotient}; the shifted remainder needs 33 bits because
  // a remainder at or above 2^31 overflows 32 bits once doubled.
  always_comb begin
    sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_q} : 33'd0);
    rem_ge  = (acc[63:31] >= {1'b0, opnd_q});
    rem_sub = acc[62:31] - opnd_q;
    if (!op_q) begin
      acc_next = {sum, acc[31:1]};
    end else if (rem_ge) begin
      acc_next = {rem_sub, acc[30:0], 1'b1};
    end else begin
      acc_next = {acc[62:0], 1'b0};
    end
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 5'd0;
      op_q     <= 1'b0;
      opnd_q   <= 32'd0;
      acc      <= 64'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q   <= op;
            opnd_q <= op ? src_b : src_a;
            acc    <= {32'd0, (op ? src_a : src_b)};
            cnt    <= 5'd0;
            if (zero_div) begin
              hi       <= src_a;
              lo       <= 32'hFFFF_FFFF;
              div_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi       <= acc_next[63:32];
            lo       <= acc_next[31:0];
            div_zero <= 1'b0;
          end
        end
        default: begin
          cnt <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Testbench for mult_div_ctrl: directed corner cases plus randomized
// operations compared with an arithmetic reference model.
module tb_mult_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int checks;
  int failures;

  mult_div_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference result: {hi, lo} computed with plain arithmetic
  function automatic logic [63:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    if (!o) return wa * wb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Launches one operation (caller is at a falling edge) and observes a fixed
  // window; inputs are scrambled right after acceptance.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input int cycles,
                        output int first_done, output int n_done, output int n_busy,
                        output logic [31:0] r_hi, output logic [31:0] r_lo, output logic r_dz,
                        output int glitches);
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    prev_hi = hi;
    prev_lo = lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    first_done = 0; n_done = 0; n_busy = 0; glitches = 0;
    r_hi = 32'd0; r_lo = 32'd0; r_dz = 1'b0;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; op = 1'($urandom); src_a = $urandom; src_b = $urandom;
      end
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = k; r_hi = hi; r_lo = lo; r_dz = div_zero;
        end
      end else if (first_done == 0 && (hi !== prev_hi || lo !== prev_lo)) begin
        glitches++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_state busy/done/dz=%b%b%b hi=%h lo=%h required 000 0 0", busy, done, div_zero, hi, lo);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic        t_op[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_a[5]   = '{32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'd5, 32'd3};
    logic [31:0] t_b[5]   = '{32'hFFFF_FFFF, 32'd7, 32'd1, 32'd0, 32'd4};
    logic [31:0] t_hi[5]  = '{32'hFFFF_FFFE, 32'd2, 32'd0, 32'd5, 32'd0};
    logic [31:0] t_lo[5]  = '{32'h0000_0001, 32'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd12};
    logic        t_dz[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int fd, nd, nb, gl;
    logic [31:0] rh, rl;
    logic rdz;
    for (int i = 0; i < 5; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 36, fd, nd, nb, rh, rl, rdz, gl);
      checks++;
      if (fd !== (t_dz[i] ? 1 : 33) || nd !== 1) begin
        failures++;
        $display("[TB] FAIL directed_latency[%0d] done_at=%0d count=%0d required %0d/1", i, fd, nd, t_dz[i] ? 1 : 33);
      end
      checks++;
      if (nb !== (t_dz[i] ? 0 : 32)) begin
        failures++;
        $display("[TB] FAIL directed_busy[%0d] busy_cycles=%0d required %0d", i, nb, t_dz[i] ? 0 : 32);
      end
      checks++;
      if (rh !== t_hi[i] || rl !== t_lo[i] || rdz !== t_dz[i] || gl !== 0) begin
        failures++;
        $display("[TB] FAIL directed_result[%0d] hi=%h lo=%h dz=%b glitch=%0d required hi=%h lo=%h dz=%b glitch=0",
                 i, rh, rl, rdz, gl, t_hi[i], t_lo[i], t_dz[i]);
      end
    end
  endtask

  task automatic test_random();
    int fd, nd, nb, gl;
    logic [31:0] rh, rl, a, b;
    logic rdz, o, exp_dz;
    logic [63:0] exp;
    for (int i = 0; i < 20; i++) begin
      o = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      exp    = model(o, a, b);
      exp_dz = o && (b == 32'd0);
      run_op(o, a, b, 36, fd, nd, nb, rh, rl, rdz, gl);
      checks++;
      if (fd !== (exp_dz ? 1 : 33) || nd !== 1 || nb !== (exp_dz ? 0 : 32)) begin
        failures++;
        $display("[TB] FAIL random_timing[%0d] done_at=%0d count=%0d busy=%0d required %0d/1/%0d",
                 i, fd, nd, nb, exp_dz ? 1 : 33, exp_dz ? 0 : 32);
      end
      checks++;
      if ({rh, rl} !== exp || rdz !== exp_dz || gl !== 0) begin
        failures++;
        $display("[TB] FAIL random_result[%0d] op=%b a=%h b=%h got %h_%h dz=%b glitch=%0d required %h dz=%b",
                 i, o, a, b, rh, rl, rdz, gl, exp, exp_dz);
      end
    end
  endtask

  task automatic test_ignore_start();
    int fd, nd;
    logic [31:0] rl, rh;
    fd = 0; nd = 0; rl = 32'd0; rh = 32'd0;
    start = 1'b1; op = 1'b0; src_a = 32'd6; src_b = 32'd7;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (fd == 0) begin fd = k; rl = lo; rh = hi; end
      end
      if (k == 1)  start = 1'b0;
      if (k == 10) begin start = 1'b1; src_a = 32'd9; end
      if (k == 11) start = 1'b0;
    end
    checks++;
    if (nd !== 1 || fd !== 33) begin
      failures++;
      $display("[TB] FAIL ignore_start_timing dones=%0d first=%0d required 1/33", nd, fd);
    end
    checks++;
    if (rl !== 32'd42 || rh !== 32'd0) begin
      failures++;
      $display("[TB] FAIL ignore_start_result hi=%h lo=%h required 0/42", rh, rl);
    end
  endtask

  task automatic test_reset_abort();
    int fd, nd, nb, gl;
    logic [31:0] rh, rl;
    logic rdz;
    run_op(1'b0, 32'd3, 32'd4, 36, fd, nd, nb, rh, rl, rdz, gl);
    checks++;
    if (lo !== 32'd12) begin
      failures++;
      $display("[TB] FAIL abort_prior lo=%h required 12", lo);
    end
    start = 1'b1; op = 1'b0; src_a = 32'd3; src_b = 32'd5;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("[TB] FAIL abort_state busy/done/dz=%b%b%b hi=%h lo=%h required 000 0 0", busy, done, div_zero, hi, lo);
    end
    rst = 1'b0;
    run_op(1'b0, 32'd7, 32'd8, 36, fd, nd, nb, rh, rl, rdz, gl);
    checks++;
    if (nd !== 1 || fd !== 33 || rl !== 32'd56 || rh !== 32'd0) begin
      failures++;
      $display("[TB] FAIL after_reset_start dones=%0d first=%0d hi=%h lo=%h required 1/33/0/56", nd, fd, rh, rl);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, nd;
    logic [31:0] l1, l2, h2;
    logic gap_busy;
    d1 = 0; d2 = 0; nd = 0; l1 = 32'd0; l2 = 32'd0; h2 = 32'd0; gap_busy = 1'b0;
    start = 1'b1; op = 1'b0; src_a = 32'd2; src_b = 32'd3;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 34) gap_busy = busy;
      if (done) begin
        nd++;
        if (d1 == 0) begin
          d1 = k; l1 = lo;
          start = 1'b1; op = 1'b1; src_a = 32'd9; src_b = 32'd2;
        end else if (d2 == 0) begin
          d2 = k; l2 = lo; h2 = hi;
        end
      end else if (d1 != 0) begin
        start = 1'b0;
      end
    end
    checks++;
    if (d1 !== 33 || l1 !== 32'd6) begin
      failures++;
      $display("[TB] FAIL b2b_first done_at=%0d lo=%h required 33/6", d1, l1);
    end
    checks++;
    if (d2 !== 66 || nd !== 2 || gap_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_second_timing done_at=%0d dones=%0d busy34=%b required 66/2/1", d2, nd, gap_busy);
    end
    checks++;
    if (l2 !== 32'd4 || h2 !== 32'd1) begin
      failures++;
      $display("[TB] FAIL b2b_second_result hi=%h lo=%h required 1/4", h2, l2);
    end
  endtask

  // Test sequence
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
